// File: rtl/flash_erase_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : flash_erase_seq_if
// Brief    : Command-issue bus between the erase sequencer and the x1 SPI engine.
// Revision : 1.0
// ============================================================================
interface flash_erase_seq_if;
    logic        o_start;
    logic [7:0]  o_cmd;
    logic [23:0] o_addr;
    logic [2:0]  o_dum_num;
    logic        o_exi_rdata;
    logic        i_rdy;
    logic [7:0]  i_data;

    modport master (
        output o_start,
        output o_cmd,
        output o_addr,
        output o_dum_num,
        output o_exi_rdata,
        input  i_rdy,
        input  i_data
    );

    modport slave (
        input  o_start,
        input  o_cmd,
        input  o_addr,
        input  o_dum_num,
        input  o_exi_rdata,
        output i_rdy,
        output i_data
    );
endinterface
`default_nettype wire

// File: rtl/flash_erase_seq.sv
`default_nettype none
// ============================================================================
// Module   : flash_erase_seq
// Brief    : Erase sequencer: WREN, erase opcode, then RDSR polls until WIP clears.
// Revision : 1.0
// ============================================================================
module flash_erase_seq #(
    parameter int POLL_GAP      = 16,
    parameter int TIMEOUT_POLLS = 1000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req,
    input  logic [1:0]        i_op,
    input  logic [23:0]       i_addr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [1:0]        o_err_code,
    flash_erase_seq_if.master eng
);

    localparam logic [7:0]  c_CMD_WREN   = 8'h06;
    localparam logic [7:0]  c_CMD_SECTOR = 8'h20;
    localparam logic [7:0]  c_CMD_BLOCK  = 8'hD8;
    localparam logic [7:0]  c_CMD_CHIP   = 8'hC7;
    localparam logic [7:0]  c_CMD_RDSR   = 8'h05;
    localparam logic [15:0] c_TIMEOUT    = 16'(TIMEOUT_POLLS);
    localparam logic [15:0] c_GAP_LAST   = 16'(POLL_GAP - 1);
    localparam logic        c_GAP_ZERO   = (POLL_GAP == 0);

    typedef enum logic [2:0] {
        S_IDLE, S_WREN, S_ERASE, S_POLL, S_GAP, S_DONE, S_ERR
    } state_t;

    typedef enum logic [1:0] {
        H_ISSUE, H_WAIT_LO, H_WAIT_HI
    } hs_t;

    state_t      r_state, w_state_nxt;
    hs_t         r_hs, w_hs_nxt;
    logic [1:0]  r_op, w_op_nxt;
    logic [23:0] r_addr_lat, w_addr_nxt;
    logic [15:0] r_poll_cnt, w_poll_nxt;
    logic [15:0] r_gap_cnt, w_gap_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;
    logic        r_err, w_err_nxt;
    logic [1:0]  r_err_code, w_code_nxt;
    logic        r_start, w_start_nxt;
    logic [7:0]  r_cmd, w_cmd_nxt;
    logic [23:0] r_eaddr, w_eaddr_nxt;
    logic        r_exi, w_exi_nxt;
    logic        w_cmd_cmplt;
    logic [7:0]  w_erase_op;
    logic [15:0] w_poll_inc;
    logic        w_unused_status;

    assign w_poll_inc      = r_poll_cnt + 16'd1;
    assign w_unused_status = &{1'b0, eng.i_data[7:1]};

    always_comb begin
        w_erase_op = c_CMD_SECTOR;
        case (r_op)
            2'd1:    w_erase_op = c_CMD_BLOCK;
            2'd2:    w_erase_op = c_CMD_CHIP;
            default: w_erase_op = c_CMD_SECTOR;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_hs       <= H_ISSUE;
            r_op       <= 2'd0;
            r_addr_lat <= 24'd0;
            r_poll_cnt <= 16'd0;
            r_gap_cnt  <= 16'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            r_start    <= 1'b0;
            r_cmd      <= 8'd0;
            r_eaddr    <= 24'd0;
            r_exi      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hs       <= w_hs_nxt;
            r_op       <= w_op_nxt;
            r_addr_lat <= w_addr_nxt;
            r_poll_cnt <= w_poll_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_err_code <= w_code_nxt;
            r_start    <= w_start_nxt;
            r_cmd      <= w_cmd_nxt;
            r_eaddr    <= w_eaddr_nxt;
            r_exi      <= w_exi_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_hs_nxt    = r_hs;
        w_op_nxt    = r_op;
        w_addr_nxt  = r_addr_lat;
        w_poll_nxt  = r_poll_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_code_nxt  = r_err_code;
        w_start_nxt = 1'b0;
        w_cmd_nxt   = r_cmd;
        w_eaddr_nxt = r_eaddr;
        w_exi_nxt   = r_exi;
        w_cmd_cmplt = 1'b0;

        // Shared engine handshake for every command-issuing state.
        if (r_state == S_WREN || r_state == S_ERASE || r_state == S_POLL) begin
            case (r_hs)
                H_ISSUE: begin
                    if (eng.i_rdy) begin
                        w_start_nxt = 1'b1;
                        w_hs_nxt    = H_WAIT_LO;
                    end
                end
                H_WAIT_LO: begin
                    if (!eng.i_rdy) w_hs_nxt = H_WAIT_HI;
                end
                H_WAIT_HI: begin
                    if (eng.i_rdy) w_cmd_cmplt = 1'b1;
                end
                default: w_hs_nxt = H_ISSUE;
            endcase
        end

        case (r_state)
            S_IDLE: begin
                if (i_req) begin
                    w_op_nxt   = i_op;
                    w_addr_nxt = i_addr;
                    w_code_nxt = 2'd0;
                    w_busy_nxt = 1'b1;
                    if (i_op == 2'd3) begin
                        w_state_nxt = S_ERR;
                        w_code_nxt  = 2'd1;
                    end else if (i_op != 2'd2 && i_addr == 24'd0) begin
                        // Address 0 means "no address phase" to the engine.
                        w_state_nxt = S_ERR;
                        w_code_nxt  = 2'd2;
                    end else begin
                        w_state_nxt = S_WREN;
                        w_hs_nxt    = H_ISSUE;
                        w_cmd_nxt   = c_CMD_WREN;
                        w_eaddr_nxt = 24'd0;
                        w_exi_nxt   = 1'b0;
                    end
                end
            end
            S_WREN: begin
                if (w_cmd_cmplt) begin
                    w_state_nxt = S_ERASE;
                    w_hs_nxt    = H_ISSUE;
                    w_cmd_nxt   = w_erase_op;
                    w_eaddr_nxt = (r_op == 2'd2) ? 24'd0 : r_addr_lat;
                    w_exi_nxt   = 1'b0;
                end
            end
            S_ERASE: begin
                if (w_cmd_cmplt) begin
                    w_state_nxt = S_POLL;
                    w_hs_nxt    = H_ISSUE;
                    w_poll_nxt  = 16'd0;
                    w_cmd_nxt   = c_CMD_RDSR;
                    w_eaddr_nxt = 24'd0;
                    w_exi_nxt   = 1'b1;
                end
            end
            S_POLL: begin
                if (w_cmd_cmplt) begin
                    w_poll_nxt = w_poll_inc;
                    if (!eng.i_data[0]) begin
                        w_state_nxt = S_DONE;
                    end else if (w_poll_inc == c_TIMEOUT) begin
                        w_state_nxt = S_ERR;
                        w_code_nxt  = 2'd3;
                    end else begin
                        w_state_nxt = S_GAP;
                        w_gap_nxt   = 16'd0;
                    end
                end
            end
            S_GAP: begin
                if (c_GAP_ZERO || r_gap_cnt == c_GAP_LAST) begin
                    w_state_nxt = S_POLL;
                    w_hs_nxt    = H_ISSUE;
                    w_cmd_nxt   = c_CMD_RDSR;
                    w_eaddr_nxt = 24'd0;
                    w_exi_nxt   = 1'b1;
                end else begin
                    w_gap_nxt = r_gap_cnt + 16'd1;
                end
            end
            S_DONE: begin
                w_done_nxt  = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            S_ERR: begin
                w_err_nxt   = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_err           = r_err;
    assign o_err_code      = r_err_code;
    assign eng.o_start     = r_start;
    assign eng.o_cmd       = r_cmd;
    assign eng.o_addr      = r_eaddr;
    assign eng.o_dum_num   = 3'd0;
    assign eng.o_exi_rdata = r_exi;

endmodule
`default_nettype wire

// File: tb/tb_flash_erase_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_erase_seq
// Brief    : Self-checking bench with a behavioural SPI engine and command-list model.
// Revision : 1.0
// ============================================================================
module tb_flash_erase_seq;

    localparam int POLL_GAP      = 3;
    localparam int TIMEOUT_POLLS = 4;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [1:0]  i_op;
    logic [23:0] i_addr;
    logic        o_busy, o_done, o_err;
    logic [1:0]  o_err_code;

    flash_erase_seq_if eng ();

    flash_erase_seq #(.POLL_GAP(POLL_GAP), .TIMEOUT_POLLS(TIMEOUT_POLLS)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (i_req),
        .i_op       (i_op),
        .i_addr     (i_addr),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_err_code (o_err_code),
        .eng        (eng)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [32:0] obs_q[$];
    logic [32:0] exp_q[$];
    int          gap_q[$];
    logic [7:0]  status_q[$];
    logic [7:0]  stat_plan[$];
    logic [7:0]  stat_dflt = 8'h00;
    int          exp_code;
    int          first_start  = -1;
    int          last_rdsr_hi = -1;
    int          done_cnt = 0;
    int          err_cnt  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural engine: drops rdy 2 cycles after start, busy 1..4 cycles.
    initial begin
        bit is_rdsr;
        int lat;
        eng.i_rdy  = 1'b1;
        eng.i_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (eng.o_start === 1'b1) begin
                is_rdsr = (eng.o_cmd == 8'h05);
                @(posedge clk); #1;
                @(posedge clk); #1;
                eng.i_rdy = 1'b0;
                lat = int'($urandom_range(1, 4));
                repeat (lat) begin @(posedge clk); #1; end
                if (is_rdsr) begin
                    if (status_q.size() > 0) eng.i_data = status_q.pop_front();
                    else                     eng.i_data = stat_dflt;
                    last_rdsr_hi = cyc;
                end
                eng.i_rdy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && eng.o_start === 1'b1) begin
            n_checks++;
            if (eng.i_rdy !== 1'b1) $display("FAIL start_while_busy: rdy=%b required 1 at cycle %0d", eng.i_rdy, cyc);
            else n_pass++;
            obs_q.push_back({eng.o_exi_rdata, eng.o_cmd, eng.o_addr});
            if (first_start < 0) first_start = cyc;
            if (eng.o_cmd == 8'h05 && last_rdsr_hi >= 0) gap_q.push_back(cyc - last_rdsr_hi);
        end
        if (o_done === 1'b1) done_cnt++;
        if (o_err === 1'b1)  err_cnt++;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_obs();
        obs_q.delete();
        gap_q.delete();
        first_start  = -1;
        last_rdsr_hi = -1;
        done_cnt     = 0;
        err_cnt      = 0;
    endtask

    // Expected command list and outcome (0 = done, else error code).
    task automatic model(input logic [1:0] op, input logic [23:0] addr);
        logic [7:0] s;
        logic [7:0] opc;
        exp_q.delete();
        if (op == 2'd3) exp_code = 1;
        else if (op != 2'd2 && addr == 24'd0) exp_code = 2;
        else begin
            opc = (op == 2'd0) ? 8'h20 : (op == 2'd1) ? 8'hD8 : 8'hC7;
            exp_q.push_back({1'b0, 8'h06, 24'h0});
            exp_q.push_back({1'b0, opc, (op == 2'd2) ? 24'h0 : addr});
            exp_code = 3;
            for (int i = 0; i < TIMEOUT_POLLS; i++) begin
                exp_q.push_back({1'b1, 8'h05, 24'h0});
                s = (i < stat_plan.size()) ? stat_plan[i] : stat_dflt;
                if (!s[0]) begin exp_code = 0; break; end
            end
        end
    endtask

    task automatic do_request(input logic [1:0] op, input logic [23:0] addr,
                              output int t_req, output int t_end,
                              output logic busy_t1, output logic [1:0] code_t1,
                              output logic busy_end);
        clear_obs();
        status_q = stat_plan;
        @(negedge clk);
        i_req = 1'b1; i_op = op; i_addr = addr; t_req = cyc;
        @(negedge clk);
        i_req = 1'b0; busy_t1 = o_busy; code_t1 = o_err_code;
        t_end = -1; busy_end = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (o_done === 1'b1 || o_err === 1'b1) begin
                t_end = cyc; busy_end = o_busy;
                break;
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_req = 1'b0; i_op = 2'd0; i_addr = 24'd0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({o_busy, o_done, o_err, o_err_code} !== 5'd0)
            $display("FAIL reset_ctrl: got %b required 00000", {o_busy, o_done, o_err, o_err_code});
        else n_pass++;
        n_checks++;
        if ({eng.o_start, eng.o_cmd, eng.o_addr, eng.o_dum_num, eng.o_exi_rdata} !== 37'd0)
            $display("FAIL reset_eng: got %h required 0", {eng.o_start, eng.o_cmd, eng.o_addr, eng.o_dum_num, eng.o_exi_rdata});
        else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sector();
        int t_req, t_end; logic b1, be; logic [1:0] c1; bit ok;
        stat_plan = '{8'h03, 8'h03, 8'h00}; stat_dflt = 8'h00;
        model(2'd0, 24'h012000);
        do_request(2'd0, 24'h012000, t_req, t_end, b1, c1, be);
        n_checks++;
        if (b1 !== 1'b1) $display("FAIL sector_busy_t1: got %b required 1", b1); else n_pass++;
        n_checks++;
        if (first_start != t_req + 2) $display("FAIL sector_first_start: got %0d required %0d", first_start, t_req + 2); else n_pass++;
        n_checks++; ok = (obs_q.size() == exp_q.size());
        for (int i = 0; ok && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) ok = 0;
        if (!ok) $display("FAIL sector_seq: got %0d cmds %p required %0d cmds %p", obs_q.size(), obs_q, exp_q.size(), exp_q); else n_pass++;
        n_checks++;
        if (done_cnt != 1 || err_cnt != 0 || be !== 1'b0)
            $display("FAIL sector_done: done=%0d err=%0d busy=%b required 1 0 0", done_cnt, err_cnt, be); else n_pass++;
        n_checks++; ok = (gap_q.size() == 2);
        foreach (gap_q[i]) if (gap_q[i] != POLL_GAP + 2) ok = 0;
        if (!ok) $display("FAIL sector_gap: got %p required two of %0d", gap_q, POLL_GAP + 2); else n_pass++;
    endtask

    task automatic test_chip();
        int t_req, t_end; logic b1, be; logic [1:0] c1; bit ok; int ones;
        ones = int'($urandom_range(0, 2));
        stat_plan.delete();
        for (int i = 0; i < ones; i++) stat_plan.push_back(8'h01 | 8'($urandom_range(0, 255)));
        stat_plan.push_back(8'($urandom_range(0, 127)) << 1);
        model(2'd2, 24'd0);
        do_request(2'd2, 24'd0, t_req, t_end, b1, c1, be);
        n_checks++; ok = (obs_q.size() == exp_q.size());
        for (int i = 0; ok && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) ok = 0;
        if (!ok) $display("FAIL chip_seq: got %p required %p", obs_q, exp_q); else n_pass++;
        n_checks++;
        if (done_cnt != 1 || err_cnt != 0) $display("FAIL chip_done: done=%0d err=%0d required 1 0", done_cnt, err_cnt); else n_pass++;
    endtask

    task automatic test_errors();
        int t_req, t_end; logic b1, be; logic [1:0] c1;
        logic [1:0]  ops[3]   = '{2'd3, 2'd0, 2'd1};
        logic [23:0] addrs[3];
        addrs[0] = 24'($urandom_range(0, 24'hFFFFFF)); addrs[1] = 24'd0; addrs[2] = 24'd0;
        stat_plan.delete();
        for (int k = 0; k < 3; k++) begin
            model(ops[k], addrs[k]);
            do_request(ops[k], addrs[k], t_req, t_end, b1, c1, be);
            n_checks++;
            if (t_end != t_req + 2 || b1 !== 1'b1 || be !== 1'b0)
                $display("FAIL err%0d_timing: t=%0d busy1=%b busyend=%b required t=%0d 1 0", k, t_end - t_req, b1, be, 2);
            else n_pass++;
            n_checks++;
            if (o_err_code !== 2'(exp_code) || err_cnt != 1 || done_cnt != 0)
                $display("FAIL err%0d_code: code=%0d err=%0d done=%0d required %0d 1 0", k, o_err_code, err_cnt, done_cnt, exp_code);
            else n_pass++;
            n_checks++;
            if (obs_q.size() != 0) $display("FAIL err%0d_nostart: got %0d starts required 0", k, obs_q.size()); else n_pass++;
        end
    endtask

    task automatic test_timeout();
        int t_req, t_end; logic b1, be; logic [1:0] c1; bit ok; logic [23:0] a;
        a = 24'($urandom_range(1, 24'hFFFFFF));
        stat_plan.delete(); stat_dflt = 8'h01;
        model(2'd1, a);
        do_request(2'd1, a, t_req, t_end, b1, c1, be);
        n_checks++; ok = (obs_q.size() == exp_q.size()) && (exp_q.size() == 2 + TIMEOUT_POLLS);
        for (int i = 0; ok && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) ok = 0;
        if (!ok) $display("FAIL timeout_seq: got %p required %p", obs_q, exp_q); else n_pass++;
        n_checks++;
        if (err_cnt != 1 || done_cnt != 0 || o_err_code !== 2'd3 || o_busy !== 1'b0)
            $display("FAIL timeout_err: err=%0d done=%0d code=%0d busy=%b required 1 0 3 0", err_cnt, done_cnt, o_err_code, o_busy);
        else n_pass++;
        stat_dflt = 8'h00;
    endtask

    task automatic test_ignore_busy();
        int t_req, t_end; logic b1, be; logic [1:0] c1; bit ok; logic [23:0] a;
        logic side_busy; bit side_ok;
        a = 24'($urandom_range(1, 24'hFFFFFF));
        stat_plan = '{8'h01, 8'h00};
        model(2'd0, a);
        side_ok = 0; side_busy = 1'b0;
        fork
            do_request(2'd0, a, t_req, t_end, b1, c1, be);
            begin
                repeat (2) @(negedge clk);
                for (int i = 0; i < 500; i++) begin
                    if (obs_q.size() >= 2) begin side_ok = 1; break; end
                    @(negedge clk);
                end
                side_busy = o_busy;
                i_req = 1'b1; i_op = 2'd3; i_addr = 24'd0;
                @(negedge clk);
                i_req = 1'b0;
            end
        join
        n_checks++;
        if (c1 !== 2'd0) $display("FAIL ignore_code_clear: got %0d required 0", c1); else n_pass++;
        n_checks++;
        if (!side_ok || side_busy !== 1'b1) $display("FAIL ignore_mid_req: reached=%0d busy=%b required 1 1", side_ok, side_busy); else n_pass++;
        n_checks++; ok = (obs_q.size() == exp_q.size());
        for (int i = 0; ok && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) ok = 0;
        if (!ok) $display("FAIL ignore_seq: got %p required %p", obs_q, exp_q); else n_pass++;
        n_checks++;
        if (done_cnt != 1 || err_cnt != 0 || o_err_code !== 2'd0)
            $display("FAIL ignore_done: done=%0d err=%0d code=%0d required 1 0 0", done_cnt, err_cnt, o_err_code);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int t_req, t_end; logic b1, be; logic [1:0] c1; bit ok, seen; logic [23:0] a;
        clear_obs();
        stat_plan = '{8'h01, 8'h01, 8'h00}; status_q = stat_plan;
        @(negedge clk);
        i_req = 1'b1; i_op = 2'd0; i_addr = 24'($urandom_range(1, 24'hFFFFFF));
        @(negedge clk);
        i_req = 1'b0;
        seen = 0;
        for (int i = 0; i < 500; i++) begin
            if (last_rdsr_hi >= 0) begin seen = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        n_checks++;
        if (!seen || o_busy !== 1'b1) $display("FAIL rstmid_in_gap: polled=%0d busy=%b required 1 1", seen, o_busy); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({o_busy, o_done, o_err, o_err_code, eng.o_start, eng.o_cmd, eng.o_addr, eng.o_dum_num, eng.o_exi_rdata} !== 42'd0)
            $display("FAIL rstmid_outputs: got %h required 0",
                     {o_busy, o_done, o_err, o_err_code, eng.o_start, eng.o_cmd, eng.o_addr, eng.o_dum_num, eng.o_exi_rdata});
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        status_q.delete();
        a = 24'($urandom_range(1, 24'hFFFFFF));
        stat_plan = '{8'h03, 8'h00};
        model(2'd0, a);
        do_request(2'd0, a, t_req, t_end, b1, c1, be);
        n_checks++; ok = (obs_q.size() == exp_q.size());
        for (int i = 0; ok && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) ok = 0;
        if (!ok || done_cnt != 1 || err_cnt != 0)
            $display("FAIL rstmid_after: got %p done=%0d err=%0d required %p 1 0", obs_q, done_cnt, err_cnt, exp_q);
        else n_pass++;
    endtask

    task automatic test_random();
        int t_req, t_end; logic b1, be; logic [1:0] c1; bit ok; logic [1:0] op; logic [23:0] a; int n;
        for (int it = 0; it < 6; it++) begin
            op = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom_range(1, 24'hFFFFFF));
            stat_plan.delete();
            n = int'($urandom_range(0, 5));
            for (int i = 0; i < n; i++) stat_plan.push_back(8'h01);
            stat_plan.push_back(8'h00);
            model(op, a);
            do_request(op, a, t_req, t_end, b1, c1, be);
            n_checks++; ok = (obs_q.size() == exp_q.size());
            for (int i = 0; ok && i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) ok = 0;
            if (!ok) $display("FAIL rand%0d_seq: op=%0d got %p required %p", it, op, obs_q, exp_q); else n_pass++;
            n_checks++;
            if (exp_code == 0) ok = (done_cnt == 1 && err_cnt == 0 && o_err_code === 2'd0);
            else               ok = (done_cnt == 0 && err_cnt == 1 && o_err_code === 2'(exp_code));
            if (!ok) $display("FAIL rand%0d_outcome: done=%0d err=%0d code=%0d required code %0d", it, done_cnt, err_cnt, o_err_code, exp_code);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_sector();
        test_chip();
        test_errors();
        test_timeout();
        test_ignore_busy();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
